// File: rtl/blueberry_pkg.sv
// Shared definitions for the blueberry core: datapath widths, register-file
// geometry and the write-back source encoding used by the arbiter.
package blueberry_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int REG_N      = 32;
  localparam int STARVE_MAX = 4;

  // Which producer owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

endpackage : blueberry_pkg

// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: ALU/LSU/MDU results in, allocation from decode,
// register-file write port and busy scoreboard out.
//
// Handshake: an LSU/MDU result transfers at a posedge where both V and Rdy
// are high; V and its DR/D must stay stable until that edge. ALU results
// have no ready and are taken every cycle Alu_V is high. Alu_Stall asks
// upstream to keep Alu_V low next cycle so a waiting slot can drain.
interface wb_arbiter_if #(
  parameter int XLEN = blueberry_pkg::XLEN
);

  // ALU
  logic                              Alu_V;
  logic [blueberry_pkg::REG_AW-1:0]  Alu_DR;
  logic [XLEN-1:0]                   Alu_D;
  logic                              Alu_Stall;
  // LSU
  logic                              Lsu_V;
  logic                              Lsu_Rdy;
  logic [blueberry_pkg::REG_AW-1:0]  Lsu_DR;
  logic [XLEN-1:0]                   Lsu_D;
  // MDU
  logic                              Mdu_V;
  logic                              Mdu_Rdy;
  logic [blueberry_pkg::REG_AW-1:0]  Mdu_DR;
  logic [XLEN-1:0]                   Mdu_D;
  // Decode allocation of long-latency destinations
  logic                              Alloc_V;
  logic [blueberry_pkg::REG_AW-1:0]  Alloc_DR;
  logic [blueberry_pkg::REG_N-1:0]   Busy;
  // Register-file write port
  logic                              RegW;
  logic [blueberry_pkg::REG_AW-1:0]  DR;
  logic [XLEN-1:0]                   Reg_In;

  // Producer / decode / register-file side
  modport master (
    output Alu_V, Alu_DR, Alu_D,
    input  Alu_Stall,
    output Lsu_V, Lsu_DR, Lsu_D,
    input  Lsu_Rdy,
    output Mdu_V, Mdu_DR, Mdu_D,
    input  Mdu_Rdy,
    output Alloc_V, Alloc_DR,
    input  Busy,
    input  RegW, DR, Reg_In
  );

  // Arbiter side
  modport slave (
    input  Alu_V, Alu_DR, Alu_D,
    output Alu_Stall,
    input  Lsu_V, Lsu_DR, Lsu_D,
    output Lsu_Rdy,
    input  Mdu_V, Mdu_DR, Mdu_D,
    output Mdu_Rdy,
    input  Alloc_V, Alloc_DR,
    output Busy,
    output RegW, DR, Reg_In
  );

endinterface : wb_arbiter_if

// File: rtl/wb_hold_slot.sv
// One-entry valid/ready hold buffer for a long-latency result source, with a
// saturating counter of cycles the held entry has waited without a grant.
module wb_hold_slot
  import blueberry_pkg::*;
#(
  parameter int DW         = XLEN,
  parameter int STARVE_MAX = blueberry_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  input  logic [REG_AW-1:0] in_dr,
  input  logic [DW-1:0]     in_d,
  output logic              rdy,
  input  logic              grant,
  output logic              slot_v,
  output logic [REG_AW-1:0] slot_dr,
  output logic [DW-1:0]     slot_d,
  output logic              starved
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] dr_q, dr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [SW-1:0]     starve_q, starve_d;

  // A granted entry leaves this cycle, so the slot can refill at the same edge.
  assign rdy     = !valid_q || grant;
  assign slot_v  = valid_q;
  assign slot_dr = dr_q;
  assign slot_d  = data_q;
  assign starved = (starve_q == STARVE_TOP);

  // Next entry and wait counter
  always_comb begin
    valid_d  = valid_q;
    dr_d     = dr_q;
    data_d   = data_q;
    starve_d = starve_q;
    if (in_v && rdy) begin
      valid_d = 1'b1;
      dr_d    = in_dr;
      data_d  = in_d;
    end else if (grant) begin
      valid_d = 1'b0;
    end
    if (grant || !valid_q) begin
      starve_d = '0;
    end else if (starve_q != STARVE_TOP) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Slot state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      dr_q     <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      valid_q  <= valid_d;
      dr_q     <= dr_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

endmodule : wb_hold_slot

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the register-file write port. ALU results
// win unconditionally; LSU/MDU results wait in hold slots and share the
// remaining cycles round-robin. Also keeps the busy scoreboard used by decode.
module wb_arbiter
  import blueberry_pkg::*;
#(
  parameter int STARVE_MAX = blueberry_pkg::STARVE_MAX
) (
  input  logic          CLK,
  input  logic          RST_N,
  wb_arbiter_if.slave   bus
);

  src_e              src;
  logic              rr_q, rr_d;          // 0: LSU preferred, 1: MDU preferred
  logic              regw_q, regw_d;
  logic [REG_AW-1:0] dr_q, dr_d;
  logic [XLEN-1:0]   reg_in_q, reg_in_d;
  logic [REG_N-1:0]  busy_q, busy_d;

  logic              lsu_v, mdu_v;
  logic [REG_AW-1:0] lsu_dr, mdu_dr;
  logic [XLEN-1:0]   lsu_d, mdu_d;
  logic              lsu_starved, mdu_starved;
  logic              lsu_grant, mdu_grant;

  assign lsu_grant = (src == SRC_LSU);
  assign mdu_grant = (src == SRC_MDU);

  wb_hold_slot #(.DW(XLEN), .STARVE_MAX(STARVE_MAX)) u_lsu_slot (
    .clk     (CLK),
    .rst_n   (RST_N),
    .in_v    (bus.Lsu_V),
    .in_dr   (bus.Lsu_DR),
    .in_d    (bus.Lsu_D),
    .rdy     (bus.Lsu_Rdy),
    .grant   (lsu_grant),
    .slot_v  (lsu_v),
    .slot_dr (lsu_dr),
    .slot_d  (lsu_d),
    .starved (lsu_starved)
  );

  wb_hold_slot #(.DW(XLEN), .STARVE_MAX(STARVE_MAX)) u_mdu_slot (
    .clk     (CLK),
    .rst_n   (RST_N),
    .in_v    (bus.Mdu_V),
    .in_dr   (bus.Mdu_DR),
    .in_d    (bus.Mdu_D),
    .rdy     (bus.Mdu_Rdy),
    .grant   (mdu_grant),
    .slot_v  (mdu_v),
    .slot_dr (mdu_dr),
    .slot_d  (mdu_d),
    .starved (mdu_starved)
  );

  // Starve counters are registered, so the stall request is glitch-free.
  assign bus.Alu_Stall = lsu_starved || mdu_starved;

  assign bus.RegW   = regw_q;
  assign bus.DR     = dr_q;
  assign bus.Reg_In = reg_in_q;
  assign bus.Busy   = busy_q;

  // Grant selection and round-robin pointer update
  always_comb begin
    src  = SRC_NONE;
    rr_d = rr_q;
    if (bus.Alu_V) begin
      src = SRC_ALU;
    end else if (lsu_v && mdu_v) begin
      src = rr_q ? SRC_MDU : SRC_LSU;
    end else if (lsu_v) begin
      src = SRC_LSU;
    end else if (mdu_v) begin
      src = SRC_MDU;
    end
    if (src == SRC_LSU) rr_d = 1'b1;
    if (src == SRC_MDU) rr_d = 1'b0;
  end

  // Register-file write port: granted entry, with writes to x0 suppressed
  always_comb begin
    regw_d   = 1'b0;
    dr_d     = dr_q;
    reg_in_d = reg_in_q;
    case (src)
      SRC_ALU: begin
        dr_d     = bus.Alu_DR;
        reg_in_d = bus.Alu_D;
      end
      SRC_LSU: begin
        dr_d     = lsu_dr;
        reg_in_d = lsu_d;
      end
      SRC_MDU: begin
        dr_d     = mdu_dr;
        reg_in_d = mdu_d;
      end
      default: ;
    endcase
    if (src != SRC_NONE) regw_d = (dr_d != '0);
  end

  // Scoreboard: clear on the edge the register file captures; a new
  // allocation of the same register on that edge wins.
  always_comb begin
    busy_d = busy_q;
    if (regw_q) busy_d[dr_q] = 1'b0;
    if (bus.Alloc_V && (bus.Alloc_DR != '0)) busy_d[bus.Alloc_DR] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Arbiter state registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rr_q     <= 1'b0;
      regw_q   <= 1'b0;
      dr_q     <= '0;
      reg_in_q <= '0;
      busy_q   <= '0;
    end else begin
      rr_q     <= rr_d;
      regw_q   <= regw_d;
      dr_q     <= dr_d;
      reg_in_q <= reg_in_d;
      busy_q   <= busy_d;
    end
  end

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU latency, LSU/MDU round-robin,
// starvation stall, scoreboard set/clear and x0 handling.
module tb_wb_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Alu_V    = 1'b0;  bus.Alu_DR = '0;  bus.Alu_D = '0;
    bus.Lsu_V    = 1'b0;  bus.Lsu_DR = '0;  bus.Lsu_D = '0;
    bus.Mdu_V    = 1'b0;  bus.Mdu_DR = '0;  bus.Mdu_D = '0;
    bus.Alloc_V  = 1'b0;  bus.Alloc_DR = '0;
  endtask

  task automatic write_chk(input string tag, input logic [4:0] dr, input logic [31:0] d);
    chk({tag, "_regw"}, 32'(bus.RegW), 32'd1);
    chk({tag, "_dr"}, 32'(bus.DR), 32'(dr));
    chk({tag, "_data"}, bus.Reg_In, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // 1: reset with every valid asserted
    bus.Alu_V = 1'b1;  bus.Alu_DR = 5'd1;  bus.Alu_D = 32'h11;
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd2;  bus.Lsu_D = 32'h22;
    bus.Mdu_V = 1'b1;  bus.Mdu_DR = 5'd3;  bus.Mdu_D = 32'h33;
    bus.Alloc_V = 1'b1; bus.Alloc_DR = 5'd7;
    repeat (3) tick();
    chk("rst_regw", 32'(bus.RegW), 32'd0);
    chk("rst_busy", bus.Busy, 32'd0);
    chk("rst_dr", 32'(bus.DR), 32'd0);
    chk("rst_regin", bus.Reg_In, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("rst_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd1);
    chk("rst_mdu_rdy", 32'(bus.Mdu_Rdy), 32'd1);
    chk("rst_stall", 32'(bus.Alu_Stall), 32'd0);
    tick();

    // 2: ALU single write, one cycle latency, one cycle only
    bus.Alu_V = 1'b1;  bus.Alu_DR = 5'd5;  bus.Alu_D = 32'h1234;
    tick();
    bus.Alu_V = 1'b0;
    write_chk("alu", 5'd5, 32'h1234);
    tick();
    chk("alu_once", 32'(bus.RegW), 32'd0);

    // 3: LSU and MDU continuously valid -> alternate starting with LSU
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd3;  bus.Lsu_D = 32'hA3;
    bus.Mdu_V = 1'b1;  bus.Mdu_DR = 5'd4;  bus.Mdu_D = 32'hB4;
    tick();
    #1;
    chk("rr_first_noreg", 32'(bus.RegW), 32'd0);
    chk("rr_first_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd1);
    chk("rr_first_mdu_rdy", 32'(bus.Mdu_Rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      if (i % 2 == 0) begin
        write_chk("rr_lsu", 5'd3, 32'hA3);
        chk("rr_mdu_rdy", 32'(bus.Mdu_Rdy), 32'd1);
      end else begin
        write_chk("rr_mdu", 5'd4, 32'hB4);
        chk("rr_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd1);
      end
    end
    bus.Lsu_V = 1'b0;
    bus.Mdu_V = 1'b0;
    tick();
    write_chk("drain_lsu", 5'd3, 32'hA3);
    tick();
    write_chk("drain_mdu", 5'd4, 32'hB4);
    tick();
    chk("drain_idle", 32'(bus.RegW), 32'd0);
    chk("drain_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd1);
    chk("drain_mdu_rdy", 32'(bus.Mdu_Rdy), 32'd1);

    // 4: ALU every cycle starves the LSU slot
    bus.Alu_V = 1'b1;  bus.Alu_DR = 5'd9;  bus.Alu_D = 32'h99;
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd6;  bus.Lsu_D = 32'h66;
    tick();
    bus.Lsu_V = 1'b0;
    #1;
    chk("stv_stall0", 32'(bus.Alu_Stall), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      #1;
      chk("stv_alu", 32'(bus.DR), 32'd9);
      chk("stv_stall", 32'(bus.Alu_Stall), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("stv_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd0);
    bus.Alu_V = 1'b0;
    #1;
    chk("stv_lsu_rdy_grant", 32'(bus.Lsu_Rdy), 32'd1);
    tick();
    write_chk("stv_lsu", 5'd6, 32'h66);
    chk("stv_stall_fall", 32'(bus.Alu_Stall), 32'd0);

    // 5: scoreboard set and clear
    bus.Alloc_V = 1'b1;  bus.Alloc_DR = 5'd7;
    tick();
    bus.Alloc_V = 1'b0;
    chk("sb_set", bus.Busy, 32'h80);
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd7;  bus.Lsu_D = 32'h77;
    tick();
    bus.Lsu_V = 1'b0;
    tick();
    write_chk("sb_wr", 5'd7, 32'h77);
    chk("sb_before_clr", bus.Busy, 32'h80);
    tick();
    chk("sb_clr", bus.Busy, 32'h0);
    // Same-edge set and clear: set wins
    bus.Alloc_V = 1'b1;  bus.Alloc_DR = 5'd7;
    tick();
    bus.Alloc_V = 1'b0;
    chk("sb_set2", bus.Busy, 32'h80);
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd7;  bus.Lsu_D = 32'h78;
    tick();
    bus.Lsu_V = 1'b0;
    tick();
    write_chk("sb_wr2", 5'd7, 32'h78);
    bus.Alloc_V = 1'b1;  bus.Alloc_DR = 5'd7;
    tick();
    bus.Alloc_V = 1'b0;
    chk("sb_set_wins", bus.Busy, 32'h80);
    tick();
    chk("sb_hold", bus.Busy, 32'h80);

    // 6: x0 handling and reset mid-stream
    bus.Alu_V = 1'b1;  bus.Alu_DR = 5'd0;  bus.Alu_D = 32'hDEAD;
    tick();
    bus.Alu_V = 1'b0;
    chk("x0_regw", 32'(bus.RegW), 32'd0);
    bus.Alloc_V = 1'b1;  bus.Alloc_DR = 5'd0;
    tick();
    bus.Alloc_V = 1'b0;
    chk("x0_busy", bus.Busy, 32'h80);
    bus.Lsu_V = 1'b1;  bus.Lsu_DR = 5'd3;  bus.Lsu_D = 32'hC3;
    bus.Mdu_V = 1'b1;  bus.Mdu_DR = 5'd4;  bus.Mdu_D = 32'hC4;
    tick();
    bus.Lsu_V = 1'b0;
    bus.Mdu_V = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_regw", 32'(bus.RegW), 32'd0);
    chk("mid_rst_busy", bus.Busy, 32'd0);
    chk("mid_rst_lsu_rdy", 32'(bus.Lsu_Rdy), 32'd1);
    chk("mid_rst_mdu_rdy", 32'(bus.Mdu_Rdy), 32'd1);
    tick();
    chk("post_rst_regw1", 32'(bus.RegW), 32'd0);
    tick();
    chk("post_rst_regw2", 32'(bus.RegW), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_arbiter
